spike_fifo: RTL

Event buffer between the LIF neuron-update core and the AER output stage of tinyODIN. Each cycle the LIF core may push the M-bit index of a neuron that fired. The output stage pops indices with a one-cycle registered read and drives them onto the AER bus. The block decouples LIF update bursts from the slower AER handshake and flags lost spikes.

---
 rtl/tinyodin_pkg.sv | 8 +
 rtl/spike_fifo_mem.sv | 34 +++
 rtl/spike_fifo.sv | 81 ++++++++
 3 files changed

// File: rtl/tinyodin_pkg.sv
// Shared tinyODIN sizing constants for the spike event path.
package tinyodin_pkg;

  localparam int unsigned SPK_ADDR_W     = 8;
  localparam int unsigned SPK_FIFO_DEPTH = 16;
  localparam int unsigned OVF_CNT_W      = 16;

endpackage : tinyodin_pkg

// File: rtl/spike_fifo_mem.sv
// DEPTH x M spike register array: one write port, one registered read port.
module spike_fifo_mem
  import tinyodin_pkg::*;
#(
  parameter int unsigned M     = SPK_ADDR_W,
  parameter int unsigned DEPTH = SPK_FIFO_DEPTH,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          clr_i,
  input  logic          w_en_i,
  input  logic [AW-1:0] w_idx_i,
  input  logic [M-1:0]  w_data_i,
  input  logic          r_en_i,
  input  logic [AW-1:0] r_idx_i,
  output logic [M-1:0]  r_data_o
);

  logic [M-1:0] mem [DEPTH];

  // Storage is intentionally not reset.
  always_ff @(posedge CLK) begin
    if (w_en_i) mem[w_idx_i] <= w_data_i;
  end

  // Head word holds until the next accepted read or a clear.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)       r_data_o <= '0;
    else if (clr_i)  r_data_o <= '0;
    else if (r_en_i) r_data_o <= mem[r_idx_i];
  end

endmodule : spike_fifo_mem

// File: rtl/spike_fifo.sv
// Spike event FIFO between the LIF core and the AER output stage.
// Define SPIKE_FIFO_OVF_CNT_EN to add a saturating dropped-spike counter.
module spike_fifo
  import tinyodin_pkg::*;
#(
  parameter int unsigned M     = SPK_ADDR_W,
  parameter int unsigned DEPTH = SPK_FIFO_DEPTH,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic                 flush_i,
  input  logic                 SPK_w_en_i,
  input  logic [M-1:0]         SPK_w_addr_i,
  output logic                 FIFO_full_o,
  output logic                 FIFO_empty_o,
  input  logic                 FIFO_r_en_i,
  output logic [M-1:0]         FIFO_r_data_o,
  output logic [AW:0]          FIFO_count_o,
  output logic                 overflow_o,
  output logic [OVF_CNT_W-1:0] ovf_count_o
);

  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          rd_acc, wr_acc, drop;

  // Flags decode only registered pointers; the MSB is the wrap bit.
  assign FIFO_empty_o = (wr_ptr == rd_ptr);
  assign FIFO_full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign FIFO_count_o = wr_ptr - rd_ptr;

  // A pop on a full FIFO frees the slot the same-cycle push lands in.
  assign rd_acc = !flush_i && FIFO_r_en_i && !FIFO_empty_o;
  assign wr_acc = !flush_i && SPK_w_en_i && (!FIFO_full_o || rd_acc);
  assign drop   = !flush_i && SPK_w_en_i && FIFO_full_o && !rd_acc;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_o <= 1'b0;
    end else if (flush_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
      if (drop)   overflow_o <= 1'b1;
    end
  end

`ifdef SPIKE_FIFO_OVF_CNT_EN
  // Saturating count of rejected pushes.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)                            ovf_count_o <= '0;
    else if (flush_i)                     ovf_count_o <= '0;
    else if (drop && (ovf_count_o != '1)) ovf_count_o <= ovf_count_o + OVF_CNT_W'(1);
  end
`else
  assign ovf_count_o = '0;
`endif

  spike_fifo_mem #(
    .M     (M),
    .DEPTH (DEPTH)
  ) u_mem (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .clr_i    (flush_i),
    .w_en_i   (wr_acc),
    .w_idx_i  (wr_ptr[AW-1:0]),
    .w_data_i (SPK_w_addr_i),
    .r_en_i   (rd_acc),
    .r_idx_i  (rd_ptr[AW-1:0]),
    .r_data_o (FIFO_r_data_o)
  );

endmodule : spike_fifo
